// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int NUM_LINES  = 32;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 5;
    localparam int TAG_W      = 22;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        REFILL  = 3'd5
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: async read by index, one sync write port
// that writes either a full refilled line or a single store word.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic                  line_we_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [LINE_W-1:0]     line_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    line_mem [NUM_LINES];

    // Next valid/dirty: refill makes a line valid and clean, a store makes it dirty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
        end
    end

    // Valid/dirty state; reset invalidates the whole cache.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: full-line refill or single-word store merge.
    // NOTE: the arrays have no reset; valid_q qualifies their contents, and a reset-free array maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_mem[idx_i]  <= line_tag_i;
            line_mem[idx_i] <= line_i;
        end else if (word_we_i) begin
            line_mem[idx_i][WORD_W*word_sel_i +: WORD_W] <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_mem[idx_i];
    assign line_o  = line_mem[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits are served in the request cycle; misses write back a dirty victim,
// refill the line, then replay the access as a hit.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]     mem_data_q, mem_data_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_write_q, mem_write_d;

    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  addr_unused;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  req, hit, idle;
    logic                  line_we, word_we;

    assign idx         = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel    = cpu_addr_i[OFFSET_W-1 -: WORD_SEL_W];
    assign addr_unused = ^cpu_addr_i[1:0];

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (idx),
        .valid_o    (rd_valid),
        .dirty_o    (rd_dirty),
        .tag_o      (rd_tag),
        .line_o     (rd_line),
        .line_we_i  (line_we),
        .line_tag_i (tag),
        .line_i     (mem_data_i),
        .word_we_i  (word_we),
        .word_sel_i (word_sel),
        .word_i     (cpu_data_i)
    );

    assign req  = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit  = rd_valid & (rd_tag == tag);
    assign idle = (state_q == IDLE);

    assign cpu_stall_o  = (idle & req & ~hit) | ~idle;
    assign cpu_data_o   = (idle & hit & cpu_MemRead_i & ~cpu_MemWrite_i)
                        ? rd_line[WORD_W*word_sel +: WORD_W] : '0;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;

    // Miss FSM next state, memory request setup and array write strobes.
    always_comb begin
        // NOTE: this block uses blocking assignments; it models combinational logic, not storage.
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_write_d  = mem_write_q;
        mem_enable_d = 1'b0;
        line_we      = 1'b0;
        word_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        word_we = cpu_MemWrite_i;
                    end else if (rd_valid && rd_dirty) begin
                        state_d      = WB_REQ;
                        mem_enable_d = 1'b1;
                        mem_write_d  = 1'b1;
                        mem_addr_d   = {rd_tag, idx, {OFFSET_W{1'b0}}};
                        mem_data_d   = rd_line;
                    end else begin
                        state_d      = RD_REQ;
                        mem_enable_d = 1'b1;
                        mem_write_d  = 1'b0;
                        mem_addr_d   = {tag, idx, {OFFSET_W{1'b0}}};
                    end
                end
            end
            WB_REQ:  state_d = WB_WAIT;
            WB_WAIT: begin
                if (mem_ack_i) begin
                    state_d      = RD_REQ;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {tag, idx, {OFFSET_W{1'b0}}};
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                line_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and memory-side output registers; reset aborts any miss in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a behavioural 8-cycle line memory,
// a table of CPU accesses with expected stall/data/memory traffic, and a
// hand-written mid-miss reset sequence.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        wb;
        logic [31:0] wb_addr;
        int          wb_sel;
        logic [31:0] wb_word;
        logic        rf;
        logic [31:0] rf_addr;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        int          sel;
        logic [31:0] word;
    } memtx_t;

    int             checks = 0;
    int             errors = 0;
    int             pulse_cnt = 0;
    memtx_t         mem_exp_q[$];
    logic [31:0]    data_exp_q[$];
    logic [255:0]   mem_model [logic [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] get_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'hC0DE_0000 ^ (a + 32'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [255:0] l;
        l = get_line({a[31:5], 5'b0});
        return l[32*a[4:2] +: 32];
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rd, input logic wr, input int stall,
                                input logic chk, input logic [31:0] exp,
                                input logic wb, input logic [31:0] wb_addr, input int wb_sel,
                                input logic [31:0] wb_word, input logic rf, input logic [31:0] rf_addr);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.exp_stall = stall;
        v.chk_data = chk; v.exp_data = exp; v.wb = wb; v.wb_addr = wb_addr;
        v.wb_sel = wb_sel; v.wb_word = wb_word; v.rf = rf; v.rf_addr = rf_addr;
        return v;
    endfunction

    // Behavioural memory: ack 8 cycles after the enable pulse; checks each request against the scoreboard.
    initial begin
        int           cnt = 0;
        logic         cap_write = 1'b0;
        logic [31:0]  cap_addr = '0;
        logic [255:0] cap_data = '0;
        memtx_t       t;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                cnt = 0;
            end else if (mem_enable_o) begin
                pulse_cnt++;
                cap_write = mem_write_o;
                cap_addr  = mem_addr_o;
                cap_data  = mem_data_o;
                cnt       = 8;
                if (mem_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req: unexpected request addr %0h write %0b", mem_addr_o, mem_write_o);
                end else begin
                    t = mem_exp_q.pop_front();
                    check("mem_write", 64'(mem_write_o), 64'(t.write));
                    check("mem_addr", 64'(mem_addr_o), 64'(t.addr));
                    if (t.write) check("wb_word", 64'(mem_data_o[32*t.sel +: 32]), 64'(t.word));
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    check("held_addr", 64'(mem_addr_o), 64'(cap_addr));
                    check("held_write", 64'(mem_write_o), 64'(cap_write));
                    mem_ack_i = 1'b1;
                    if (cap_write) mem_model[cap_addr] = cap_data;
                    else mem_data_i = get_line(cap_addr);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int n);
        int          stall_cnt;
        int          p0;
        logic [31:0] exp;
        string       tag;
        tag = $sformatf("v%0d", n);
        p0  = pulse_cnt;
        if (v.wb) mem_exp_q.push_back('{1'b1, v.wb_addr, v.wb_sel, v.wb_word});
        if (v.rf) mem_exp_q.push_back('{1'b0, v.rf_addr, 0, 32'h0});
        if (v.chk_data) data_exp_q.push_back(v.exp_data);
        @(negedge clk_i);
        cpu_addr_i     = v.addr;
        cpu_data_i     = v.wdata;
        cpu_MemRead_i  = v.rd;
        cpu_MemWrite_i = v.wr;
        #1;
        stall_cnt = 0;
        while (cpu_stall_o && stall_cnt < 200) begin
            stall_cnt++;
            @(negedge clk_i);
            #1;
        end
        check({tag, "_stall"}, 64'(stall_cnt), 64'(v.exp_stall));
        if (v.chk_data) begin
            exp = data_exp_q.pop_front();
            check({tag, "_rdata"}, 64'(cpu_data_o), 64'(exp));
        end
        check({tag, "_pulses"}, 64'(pulse_cnt - p0), 64'(int'(v.wb) + int'(v.rf)));
        check({tag, "_pending"}, 64'(mem_exp_q.size()), 64'd0);
        @(negedge clk_i);
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        vec_t post[3];
        int   p0;
        int   n;

        rst_i          = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;

        vecs[0]  = mk(32'h040, 32'h0, 1, 0, 11, 1, mem_word(32'h040), 0, 0, 0, 0, 1, 32'h040);
        vecs[1]  = mk(32'h044, 32'h0, 1, 0, 0,  1, mem_word(32'h044), 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(32'h048, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(32'h048, 32'h0, 1, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(32'h440, 32'h0, 1, 0, 20, 1, mem_word(32'h440), 1, 32'h040, 2, 32'hDEADBEEF, 1, 32'h440);
        vecs[5]  = mk(32'h0A0, 32'h12345678, 0, 1, 11, 0, 0, 0, 0, 0, 0, 1, 32'h0A0);
        vecs[6]  = mk(32'h0A0, 32'h0, 1, 0, 0,  1, 32'h12345678, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(32'h04C, 32'h0, 1, 0, 11, 1, mem_word(32'h04C), 0, 0, 0, 0, 1, 32'h040);
        vecs[8]  = mk(32'h048, 32'h0, 1, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(32'h0A4, 32'h55AA55AA, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(32'h0A4, 32'h0, 1, 0, 0,  1, 32'h55AA55AA, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(32'h4A0, 32'h0, 1, 0, 20, 1, mem_word(32'h4A0), 1, 32'h0A0, 0, 32'h12345678, 1, 32'h4A0);

        post[0] = mk(32'h044, 32'h0, 1, 0, 11, 1, 32'hC0DE0044, 0, 0, 0, 0, 1, 32'h040);
        post[1] = mk(32'h4A0, 32'h0, 1, 0, 11, 1, mem_word(32'h4A0), 0, 0, 0, 0, 1, 32'h4A0);
        post[2] = mk(32'h300, 32'h0, 1, 0, 11, 1, mem_word(32'h300), 0, 0, 0, 0, 1, 32'h300);

        // Reset values
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_stall", 64'(cpu_stall_o), 64'd0);
        check("rst_enable", 64'(mem_enable_o), 64'd0);
        check("rst_write", 64'(mem_write_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_mdata", 64'(mem_data_o[63:0]), 64'd0);
        check("rst_cdata", 64'(cpu_data_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset dropped while the refill is outstanding
        mem_exp_q.push_back('{1'b0, 32'h300, 0, 32'h0});
        @(negedge clk_i);
        cpu_addr_i    = 32'h300;
        cpu_MemRead_i = 1'b1;
        p0 = pulse_cnt;
        n  = 0;
        while (pulse_cnt == p0 && n < 20) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("abort_req_seen", 64'(pulse_cnt - p0), 64'd1);
        repeat (3) @(negedge clk_i);
        #1;
        check("abort_in_wait", 64'(cpu_stall_o), 64'd1);
        rst_i = 1'b0;
        #1;
        check("abort_enable", 64'(mem_enable_o), 64'd0);
        check("abort_write", 64'(mem_write_o), 64'd0);
        check("abort_addr", 64'(mem_addr_o), 64'd0);
        check("abort_cdata", 64'(cpu_data_o), 64'd0);
        check("abort_stall_req", 64'(cpu_stall_o), 64'd1);
        cpu_MemRead_i = 1'b0;
        #1;
        check("abort_stall_idle", 64'(cpu_stall_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 3; i++) run_vec(post[i], 12 + i);

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
